fb_mem_arbiter: RTL and testbench
=================================

// Module: fb_mem_arbiter
// PURPOSE
// Shares one single-port, synchronous-read framebuffer SRAM between the video scanout fetcher
// (latency-critical, default priority) and the Wishbone host port (config/pixel writes, readback).
// Sits between the wishbone bus, the line fetcher feeding dvid/vga/dac shifters, and the SRAM macro.
// Starvation guard guarantees the host a slot after STARVE_MAX consecutive losses.
// PARAMETERS
// ADDR_W      10  SRAM word-address width (depth 2**ADDR_W words)
// DATA_W      32  SRAM/bus data width; byte enables = DATA_W/8
// STARVE_MAX  8   consecutive lost arbitration cycles before host is forced a slot (1..255)
// PORTS
// clk         in   1        system clock (wb_clk_i domain)
// reset_n     in   1        asynchronous active-low reset
// wb__cyc     in   1        wishbone cycle
// wb__stb     in   1        wishbone strobe
// wb__we      in   1        wishbone write enable
// wb__sel     in   DATA_W/8 wishbone byte selects
// wb__adr     in   32       byte address; word index = wb__adr[ADDR_W+1:2], other bits ignored
// wb__dat_w   in   DATA_W   write data
// wb__dat_r   out  DATA_W   read data, valid while wb__ack
// wb__ack     out  1        one-cycle acknowledge
// vid_req     in   1        fetcher read request (level)
// vid_adr     in   ADDR_W   fetcher word address, held until vid_gnt
// vid_gnt     out  1        fetcher request issued to SRAM this cycle
// vid_valid   out  1        vid_dat valid (one cycle after vid_gnt)
// vid_dat     out  DATA_W   fetch data
// mem_en      out  1        SRAM enable
// mem_we      out  DATA_W/8 SRAM byte write enables
// mem_adr     out  ADDR_W   SRAM address
// mem_wdat    out  DATA_W   SRAM write data
// mem_rdat    in   DATA_W   SRAM read data, valid cycle after mem_en with mem_we==0
// BEHAVIOUR
// - Reset: all outputs 0, host FSM IDLE, starve counter 0. Reset mid-transaction abandons it: no ack.
// - mem_* are registered: arbitration decided at edge E, access on bus for cycle after E.
//   vid_gnt/host issue coincide with mem_en; at most one access per cycle; mem_en=0 when none.
// - Host FSM: IDLE -> ISSUE (when cyc&stb and host wins) -> WAIT -> ACK -> IDLE.
//   ISSUE: mem_en=1, mem_we=wb__we?wb__sel:0, mem_adr/wdat from bus. WAIT: capture mem_rdat into
//   wb__dat_r (reads; writes leave it unchanged). ACK: wb__ack=1 exactly one cycle.
//   Host latency: issue + 2 cycles to ack; ACK->IDLE does not resample stb in ACK cycle.
//   cyc or stb dropped while IDLE: no request. Dropped after ISSUE: access completes, ack still pulsed.
// - Arbitration (only while host FSM IDLE with cyc&stb, else video owns every cycle):
//   vid_req=0 -> host wins; vid_req=1 and starve<STARVE_MAX -> video wins, starve+=1;
//   starve==STARVE_MAX -> host wins. starve clears on host issue and when host not pending.
// - Video may issue back-to-back every cycle, incl. during host WAIT/ACK; vid_adr may change the
//   cycle after vid_gnt. vid_valid = vid_gnt delayed 1; vid_dat = mem_rdat (combinational).
// - Video worst-case stall: 1 cycle per (STARVE_MAX+1) while host is continuously busy.
// - Counter never wraps: saturates at STARVE_MAX; STARVE_MAX fits 8 bits.
// CONFIGURATION
// FB_ARB_PERF_EN defined: adds output perf_vid_stall [15:0], count of cycles with vid_req=1 and
//   vid_gnt=0 (vid_gnt compared one cycle late, aligned), saturating at 16'hFFFF, cleared by reset
//   and by a host write with wb__adr[31]=1 (write still performed to SRAM address bits).
// Not defined: port absent, no counter logic; behaviour otherwise identical.
// TESTING
// 1 reset_n low mid host read at WAIT -> all outputs 0, no wb__ack after release, next read works.
// 2 Host write adr=0x10 dat=0xDEADBEEF sel=4'b0011, vid_req=0 -> mem_we=4'b0011 adr=4, ack at +3
//   edges; later read adr=0x10 after preload 0 -> wb__dat_r=0x0000BEEF.
// 3 vid_req held 1, adr stepping 0..15 each gnt, no host -> vid_gnt every cycle, vid_valid one
//   cycle later with data matching preloaded words 0..15.
// 4 vid_req held 1 + host read pending, STARVE_MAX=8 -> host issued exactly on 9th arbitration
//   cycle, one vid_gnt gap, starve returns to 0, ack 2 cycles after issue.
// 5 Host requests simultaneously with vid_req=0 -> host wins immediately; following cycle video
//   granted while host in WAIT, no mem_en collision (never two issues same cycle).
// 6 FB_ARB_PERF_EN: case 4 repeated 3 times -> perf_vid_stall=3; write adr=0x8000_0000 -> 0.

Source files
------------

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter
// Shares one single-port, synchronous-read framebuffer SRAM between the video
// scanout fetcher (default priority) and the Wishbone host port. A starvation
// counter forces a host slot after STARVE_MAX consecutive lost arbitrations.
//
// Parameters
//   ADDR_W      SRAM word-address width
//   DATA_W      SRAM / bus data width (byte enables = DATA_W/8)
//   STARVE_MAX  consecutive host losses before the host is forced a slot (1..255)
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   wb__cyc/stb/we/sel/adr/dat_w  Wishbone request; word index = wb__adr[ADDR_W+1:2]
//   wb__dat_r, wb__ack            Wishbone read data / one-cycle acknowledge
//   vid_req, vid_adr              fetcher read request (level) and word address
//   vid_gnt, vid_valid, vid_dat   fetch issued this cycle / data valid next cycle / data
//   mem_en/we/adr/wdat            registered SRAM command
//   mem_rdat                      SRAM read data, valid the cycle after a read
//   perf_vid_stall                (FB_ARB_PERF_EN only) saturating video stall count
//
// Build option
//   FB_ARB_PERF_EN  adds perf_vid_stall; cleared by reset or by a host write
//                   with wb__adr[31]=1 (the write still goes to SRAM).
//
// Host FSM
//   state    | meaning
//   ST_IDLE  | no host access in flight; arbitrates when cyc&stb
//   ST_ISSUE | host command on the SRAM port this cycle
//   ST_WAIT  | SRAM read data returning; captured into wb__dat_r for reads
//   ST_ACK   | wb__ack high for exactly this cycle

module fb_mem_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                wb__cyc,
   input  logic                wb__stb,
   input  logic                wb__we,
   input  logic [DATA_W/8-1:0] wb__sel,
   input  logic [31:0]         wb__adr,
   input  logic [DATA_W-1:0]   wb__dat_w,
   output logic [DATA_W-1:0]   wb__dat_r,
   output logic                wb__ack,
   input  logic                vid_req,
   input  logic [ADDR_W-1:0]   vid_adr,
   output logic                vid_gnt,
   output logic                vid_valid,
   output logic [DATA_W-1:0]   vid_dat,
   output logic                mem_en,
   output logic [DATA_W/8-1:0] mem_we,
   output logic [ADDR_W-1:0]   mem_adr,
   output logic [DATA_W-1:0]   mem_wdat,
`ifdef FB_ARB_PERF_EN
   output logic [15:0]         perf_vid_stall,
`endif
   input  logic [DATA_W-1:0]   mem_rdat
);

   localparam int SEL_W = DATA_W / 8;
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_ACK
   } host_state_t;

   host_state_t state, state_nxt;
   logic [7:0]  starve_cnt, starve_nxt;
   logic        host_pend;
   logic        host_issue;
   logic        vid_issue;
   logic        host_we_q;
   logic        adr_unused;

   // Address bits outside the word index carry no meaning for the SRAM.
   assign adr_unused = ^{wb__adr[31:ADDR_W+2], wb__adr[1:0]};

   assign host_pend = (state == ST_IDLE) && wb__cyc && wb__stb;
   assign wb__ack   = (state == ST_ACK);
   assign vid_dat   = mem_rdat;

   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
      host_issue = 1'b0;
      vid_issue  = 1'b0;

      // Host only competes from IDLE; otherwise video owns every slot.
      if (host_pend) begin
         if (!vid_req || (starve_cnt == STARVE_LIM)) begin
            host_issue = 1'b1;
            starve_nxt = '0;
         end else begin
            vid_issue  = 1'b1;
            starve_nxt = starve_cnt + 8'd1;
         end
      end else begin
         vid_issue  = vid_req;
         starve_nxt = '0;
      end

      unique case (state)
         ST_IDLE:  if (host_issue) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  state_nxt = ST_ACK;
         ST_ACK:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         starve_cnt <= '0;
         host_we_q  <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= '0;
         mem_adr    <= '0;
         mem_wdat   <= '0;
         vid_gnt    <= 1'b0;
         vid_valid  <= 1'b0;
         wb__dat_r  <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         mem_en     <= host_issue || vid_issue;
         mem_we     <= (host_issue && wb__we) ? wb__sel : {SEL_W{1'b0}};
         if (host_issue) begin
            mem_adr <= wb__adr[ADDR_W+1:2];
         end else if (vid_issue) begin
            mem_adr <= vid_adr;
         end else begin
            mem_adr <= '0;
         end
         mem_wdat   <= host_issue ? wb__dat_w : '0;
         vid_gnt    <= vid_issue;
         vid_valid  <= vid_gnt;
         if (host_issue) begin
            host_we_q <= wb__we;
         end
         if ((state == ST_WAIT) && !host_we_q) begin
            wb__dat_r <= mem_rdat;
         end
      end
   end

`ifdef FB_ARB_PERF_EN
   // vid_req is delayed one cycle so it lines up with the vid_gnt it produced.
   logic vid_req_q;
   logic perf_clr;

   assign perf_clr = host_issue && wb__we && wb__adr[31];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vid_req_q      <= 1'b0;
         perf_vid_stall <= '0;
      end else begin
         vid_req_q <= vid_req;
         if (perf_clr) begin
            perf_vid_stall <= '0;
         end else if (vid_req_q && !vid_gnt && (perf_vid_stall != 16'hFFFF)) begin
            perf_vid_stall <= perf_vid_stall + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Self-checking bench for fb_mem_arbiter: SRAM model, auto-stepping fetcher,
// a table of host transactions, and directed multi-cycle sequences.

module tb_fb_mem_arbiter;

   logic        clk;
   logic        reset_n;
   logic        wb_cyc, wb_stb, wb_we;
   logic [3:0]  wb_sel;
   logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
   logic        wb_ack;
   logic        vid_req;
   logic [9:0]  vid_adr;
   logic        vid_gnt, vid_valid;
   logic [31:0] vid_dat;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [9:0]  mem_adr;
   logic [31:0] mem_wdat, mem_rdat;
`ifdef FB_ARB_PERF_EN
   logic [15:0] perf_vid_stall;
`endif

   logic        fetch_clr;
   int          n_chk;
   int          n_err;

   fb_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .wb__cyc   (wb_cyc),
      .wb__stb   (wb_stb),
      .wb__we    (wb_we),
      .wb__sel   (wb_sel),
      .wb__adr   (wb_adr),
      .wb__dat_w (wb_dat_w),
      .wb__dat_r (wb_dat_r),
      .wb__ack   (wb_ack),
      .vid_req   (vid_req),
      .vid_adr   (vid_adr),
      .vid_gnt   (vid_gnt),
      .vid_valid (vid_valid),
      .vid_dat   (vid_dat),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_adr   (mem_adr),
      .mem_wdat  (mem_wdat),
`ifdef FB_ARB_PERF_EN
      .perf_vid_stall (perf_vid_stall),
`endif
      .mem_rdat  (mem_rdat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: word 4 preloaded with 0, every other word i with A500_0000|i.
   logic [31:0] sram [0:1023];
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 1024; i++)
            sram[i] <= (i == 4) ? 32'h0 : (32'hA500_0000 | 32'(i));
         mem_rdat <= '0;
      end else if (mem_en) begin
         if (mem_we == 4'b0000)
            mem_rdat <= sram[mem_adr];
         else
            for (int b = 0; b < 4; b++)
               if (mem_we[b]) sram[mem_adr][8*b +: 8] <= mem_wdat[8*b +: 8];
      end
   end

   // Fetcher: advances its address between a grant and the next decision edge.
   always @(negedge clk) begin
      if (fetch_clr)
         vid_adr <= '0;
      else if (vid_gnt)
         vid_adr <= vid_adr + 10'd1;
   end

   function automatic logic [31:0] exp_pre(input int i);
      return (i == 4) ? 32'h0 : (32'hA500_0000 | 32'(i));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic host_go(input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
      wb_sel = sel;  wb_adr = adr;  wb_dat_w = dat;
   endtask

   task automatic host_drop();
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   task automatic fetch_reset();
      fetch_clr = 1'b1;
      tick();
      fetch_clr = 1'b0;
   endtask

   // Waits (bounded) for the ack; records the host issue cycle and command.
   task automatic host_wait_ack(input int max_cyc, output int t_iss, output int t_ack,
                                output logic [3:0] we_s, output logic [9:0] adr_s,
                                output logic [31:0] wd_s);
      t_iss = -1; t_ack = -1; we_s = 'x; adr_s = 'x; wd_s = 'x;
      for (int k = 1; k <= max_cyc; k++) begin
         tick();
         if (t_iss < 0 && mem_en && !vid_gnt) begin
            t_iss = k; we_s = mem_we; adr_s = mem_adr; wd_s = mem_wdat;
         end
         if (wb_ack) begin
            t_ack = k;
            break;
         end
      end
      host_drop();
   endtask

   // Host read of word 33 against a continuously requesting fetcher.
   task automatic starve_run(input int run);
      int         t_iss, t_ack, gaps;
      logic [9:0] adr_s;
      t_iss = -1; t_ack = -1; gaps = 0; adr_s = 'x;
      vid_req = 1'b1;
      host_go(1'b0, 4'hF, 32'h84, 32'h0);
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (!vid_gnt) gaps++;
         if (t_iss < 0 && mem_en && !vid_gnt) begin
            t_iss = k; adr_s = mem_adr;
         end
         if (wb_ack) begin
            t_ack = k;
            break;
         end
      end
      host_drop();
      vid_req = 1'b0;
      chk($sformatf("starve%0d_issue_cycle", run), t_iss, 9);
      chk($sformatf("starve%0d_ack_cycle", run), t_ack, 11);
      chk($sformatf("starve%0d_gnt_gaps", run), gaps, 1);
      chk($sformatf("starve%0d_adr", run), adr_s, 33);
      chk($sformatf("starve%0d_dat_r", run), wb_dat_r, 32'hA500_0021);
      tick();
      tick();
   endtask

   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  exp_we;
      logic [9:0]  exp_adr;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vt [9];

   initial begin
      int         t_iss, t_ack, acks;
      logic [3:0] we_s;
      logic [9:0] adr_s;
      logic [31:0] wd_s;

      n_chk = 0; n_err = 0;
      vt[0] = '{1'b1, 4'b0011, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0011, 10'd4,    32'hA500_0021};
      vt[1] = '{1'b0, 4'b1111, 32'h0000_0010, 32'h0,         4'b0000, 10'd4,    32'h0000_BEEF};
      vt[2] = '{1'b1, 4'b1111, 32'hFFFF_F00C, 32'h1234_5678, 4'b1111, 10'd3,    32'h0000_BEEF};
      vt[3] = '{1'b0, 4'b1111, 32'h0000_000C, 32'h0,         4'b0000, 10'd3,    32'h1234_5678};
      vt[4] = '{1'b1, 4'b1100, 32'h0000_0020, 32'hCAFE_F00D, 4'b1100, 10'd8,    32'h1234_5678};
      vt[5] = '{1'b0, 4'b0001, 32'h0000_0020, 32'h0,         4'b0000, 10'd8,    32'hCAFE_0008};
      vt[6] = '{1'b0, 4'b1111, 32'h0000_0FFC, 32'h0,         4'b0000, 10'd1023, 32'hA500_03FF};
      vt[7] = '{1'b1, 4'b0000, 32'h0000_0014, 32'hFFFF_FFFF, 4'b0000, 10'd5,    32'hA500_03FF};
      vt[8] = '{1'b0, 4'b1111, 32'h0000_0014, 32'h0,         4'b0000, 10'd5,    32'hA500_0005};

      reset_n = 1'b0; fetch_clr = 1'b1; vid_req = 1'b0;
      wb_sel = '0; wb_adr = '0; wb_dat_w = '0;
      host_drop();
      tick(); tick();
      fetch_clr = 1'b0;
      chk("reset_outputs",
          {wb_ack, wb_dat_r, vid_gnt, vid_valid, vid_dat, mem_en, mem_we, mem_adr, mem_wdat}, 0);
      reset_n = 1'b1;
      tick();

      // Reset during host read WAIT.
      host_go(1'b0, 4'hF, 32'h8, 32'h0);
      tick();
      chk("pre_rst_issue", {mem_en, mem_adr}, {1'b1, 10'd2});
      tick();
      reset_n = 1'b0;
      host_drop();
      #1;
      chk("midrst_outputs",
          {wb_ack, wb_dat_r, vid_gnt, vid_valid, vid_dat, mem_en, mem_we, mem_adr, mem_wdat}, 0);
      tick(); tick();
      reset_n = 1'b1;
      acks = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (wb_ack) acks++;
      end
      chk("no_ack_after_rst", acks, 0);
      host_go(1'b0, 4'hF, 32'h8, 32'h0);
      host_wait_ack(8, t_iss, t_ack, we_s, adr_s, wd_s);
      chk("post_rst_issue", t_iss, 1);
      chk("post_rst_ack", t_ack, 3);
      chk("post_rst_dat_r", wb_dat_r, 32'hA500_0002);
      tick();

      // Back-to-back video fetch of words 0..15.
      fetch_reset();
      vid_req = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (k <= 16) begin
            chk($sformatf("vid_gnt_c%0d", k), vid_gnt, 1);
            chk($sformatf("vid_adr_c%0d", k), mem_adr, k - 1);
         end else begin
            chk("vid_gnt_after_drop", vid_gnt, 0);
         end
         if (k == 1) chk("vid_valid_c1", vid_valid, 0);
         else begin
            chk($sformatf("vid_valid_c%0d", k), vid_valid, 1);
            chk($sformatf("vid_dat_c%0d", k), vid_dat, exp_pre(k - 2));
         end
         if (k == 16) vid_req = 1'b0;
      end
      tick();

      // Host wins with vid_req low, video takes the slot during host WAIT.
      fetch_reset();
      host_go(1'b0, 4'hF, 32'h80, 32'h0);
      tick();
      chk("c5_issue", {mem_en, vid_gnt, mem_we, mem_adr}, {1'b1, 1'b0, 4'b0000, 10'd32});
      vid_req = 1'b1;
      tick();
      chk("c5_wait_vid", {mem_en, vid_gnt, mem_adr, wb_ack}, {1'b1, 1'b1, 10'd0, 1'b0});
      tick();
      chk("c5_ack", wb_ack, 1);
      chk("c5_dat_r", wb_dat_r, 32'hA500_0020);
      chk("c5_ack_vid", {vid_gnt, mem_adr, vid_valid}, {1'b1, 10'd1, 1'b1});
      chk("c5_vid_dat", vid_dat, exp_pre(0));
      host_drop();
      vid_req = 1'b0;
      tick(); tick();

`ifdef FB_ARB_PERF_EN
      host_go(1'b1, 4'hF, 32'h8000_0000, 32'h1111_1111);
      host_wait_ack(8, t_iss, t_ack, we_s, adr_s, wd_s);
      tick();
      chk("perf_clr0", perf_vid_stall, 0);
`endif

      // Starvation guard, three times in a row.
      fetch_reset();
      for (int r = 0; r < 3; r++) starve_run(r);

`ifdef FB_ARB_PERF_EN
      chk("perf_after_3", perf_vid_stall, 3);
`endif

      // Table of host transactions with the fetcher idle.
      for (int i = 0; i < 9; i++) begin
         host_go(vt[i].we, vt[i].sel, vt[i].adr, vt[i].dat);
         host_wait_ack(8, t_iss, t_ack, we_s, adr_s, wd_s);
         chk($sformatf("v%0d_issue", i), t_iss, 1);
         chk($sformatf("v%0d_ack", i), t_ack, 3);
         chk($sformatf("v%0d_mem_we", i), we_s, vt[i].exp_we);
         chk($sformatf("v%0d_mem_adr", i), adr_s, vt[i].exp_adr);
         if (vt[i].we) chk($sformatf("v%0d_mem_wdat", i), wd_s, vt[i].dat);
         chk($sformatf("v%0d_dat_r", i), wb_dat_r, vt[i].exp_rd);
         tick();
      end

`ifdef FB_ARB_PERF_EN
      host_go(1'b1, 4'hF, 32'h8000_0000, 32'h2222_2222);
      host_wait_ack(8, t_iss, t_ack, we_s, adr_s, wd_s);
      chk("perf_clr_write_adr", {we_s, adr_s}, {4'hF, 10'd0});
      tick();
      chk("perf_clr1", perf_vid_stall, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
